// File: rtl/rast_iter_pkg.sv
// rast_iter_pkg: shared constants, types and step helper for the bbox sample iterator
package rast_iter_pkg;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef logic signed [SIGFIG-1:0] fix_t;
    typedef enum logic {WAIT, TEST} state_t;

    // one-hot MSAA code scaled so 1x lands on 1.0 and 64x on 0.125
    function automatic fix_t step_from_subsample(input logic [3:0] sub);
        return fix_t'({{(SIGFIG-4){1'b0}}, sub} << (RADIX - 3));
    endfunction
endpackage

// File: rtl/bbox_sample_iter.sv
// bbox_sample_iter: walks every subsample of a clipped bbox in raster order, holding upstream while busy
module bbox_sample_iter
    import rast_iter_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  fix_t [VERTS-1:0][AXIS-1:0]     tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]  color_R13U,
    input  fix_t [1:0][1:0]                box_R13S,
    input  logic                           validTri_R13H,
    input  logic [3:0]                     subSample_RnnnnU,
    input  logic                           halt_RnnnnL,
    output logic                           haltUp_RnnnnL,
    output fix_t [VERTS-1:0][AXIS-1:0]     tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]  color_R14U,
    output fix_t [1:0]                     sample_R14S,
    output logic                           validSamp_R14H
);
    state_t          state, state_nxt;
    fix_t [1:0][1:0] box_q;
    fix_t            step_q;
    fix_t [1:0]      walk, samp_nxt;
    logic            accept, valid_nxt, row_end;

    assign haltUp_RnnnnL = halt_RnnnnL && (state == WAIT);

    always_comb begin
        row_end   = !(sample_R14S[0] < box_q[1][0]);
        walk[0]   = row_end ? box_q[0][0] : sample_R14S[0] + step_q;
        walk[1]   = row_end ? sample_R14S[1] + step_q : sample_R14S[1];
        accept    = (state == WAIT) && validTri_R13H;
        samp_nxt  = (state == TEST) ? walk : accept ? box_R13S[0] : sample_R14S;
        valid_nxt = (state == TEST) || validTri_R13H;
        state_nxt = (state == TEST) ? ((walk == box_q[1]) ? WAIT : TEST)
                  : (accept && box_R13S[0] != box_R13S[1]) ? TEST : WAIT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= WAIT;
            sample_R14S    <= '0;
            validSamp_R14H <= 1'b0;
            tri_R14S       <= '0;
            color_R14U     <= '0;
            box_q          <= '0;
            step_q         <= '0;
        end else if (halt_RnnnnL) begin
            state          <= state_nxt;
            sample_R14S    <= samp_nxt;
            validSamp_R14H <= valid_nxt;
            if (accept) begin
                tri_R14S   <= tri_R13S;
                color_R14U <= color_R13U;
                box_q      <= box_R13S;
                step_q     <= step_from_subsample(subSample_RnnnnU);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        (halt_RnnnnL && accept) |-> (box_R13S[0][0] <= box_R13S[1][0] && box_R13S[0][1] <= box_R13S[1][1]));
    assert property (@(posedge clk) disable iff (!rst)
        (halt_RnnnnL && accept) |-> $onehot(subSample_RnnnnU));
    assert property (@(posedge clk) disable iff (!rst)
        validSamp_R14H |-> (sample_R14S[0] >= box_q[0][0] && sample_R14S[0] <= box_q[1][0]
                         && sample_R14S[1] >= box_q[0][1] && sample_R14S[1] <= box_q[1][1]));
endmodule

// File: tb/tb_bbox_sample_iter.sv
// tb_bbox_sample_iter: directed scenarios checked against a queue-based sample model every cycle
module tb_bbox_sample_iter;
    import rast_iter_pkg::*;

    typedef struct {int x; int y;} pt_t;

    logic                          clk = 0;
    logic                          rst;
    fix_t [VERTS-1:0][AXIS-1:0]    tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0] color_R13U;
    fix_t [1:0][1:0]               box_R13S;
    logic                          validTri_R13H;
    logic [3:0]                    subSample_RnnnnU;
    logic                          halt_RnnnnL;
    logic                          haltUp_RnnnnL;
    fix_t [VERTS-1:0][AXIS-1:0]    tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0] color_R14U;
    fix_t [1:0]                    sample_R14S;
    logic                          validSamp_R14H;

    int tests = 0;
    int fails = 0;
    int lowcnt = 0;
    int wx[8], wy[8];
    pt_t logq[$];

    pt_t pend[$];
    pt_t p;
    int  ex = 0, ey = 0;
    bit  ev = 0;
    logic [VERTS*AXIS*SIGFIG-1:0] etri = '0;
    logic [COLORS*SIGFIG-1:0]     ecol = '0;

    bbox_sample_iter dut (
        .clk(clk), .rst(rst),
        .tri_R13S(tri_R13S), .color_R13U(color_R13U), .box_R13S(box_R13S),
        .validTri_R13H(validTri_R13H), .subSample_RnnnnU(subSample_RnnnnU),
        .halt_RnnnnL(halt_RnnnnL), .haltUp_RnnnnL(haltUp_RnnnnL),
        .tri_R14S(tri_R14S), .color_R14U(color_R14U),
        .sample_R14S(sample_R14S), .validSamp_R14H(validSamp_R14H)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: a box expands into its full sample list; one sample leaves the list per enabled cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend.delete();
            ex = 0;
            ey = 0;
            ev = 0;
            etri = '0;
            ecol = '0;
        end else if (halt_RnnnnL) begin
            if (pend.size() != 0) begin
                p = pend.pop_front();
                ex = p.x;
                ey = p.y;
                ev = 1;
            end else if (validTri_R13H) begin
                int st;
                st = (subSample_RnnnnU == 4'b1000) ? 'h400 : (subSample_RnnnnU == 4'b0100) ? 'h200
                   : (subSample_RnnnnU == 4'b0010) ? 'h100 : 'h80;
                for (int y = int'(box_R13S[0][1]); y <= int'(box_R13S[1][1]); y += st)
                    for (int x = int'(box_R13S[0][0]); x <= int'(box_R13S[1][0]); x += st)
                        pend.push_back('{x, y});
                p = pend.pop_front();
                ex = p.x;
                ey = p.y;
                ev = 1;
                etri = tri_R13S;
                ecol = color_R13U;
            end else begin
                ev = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", 256'(validSamp_R14H), 256'(ev));
        chk("haltUp", 256'(haltUp_RnnnnL), 256'(halt_RnnnnL && pend.size() == 0));
        chk("samp_x", 256'(sample_R14S[0]), 256'(ex));
        chk("samp_y", 256'(sample_R14S[1]), 256'(ey));
        chk("tri", 256'(tri_R14S), 256'(etri));
        chk("color", 256'(color_R14U), 256'(ecol));
        if (validSamp_R14H && halt_RnnnnL) logq.push_back('{int'(sample_R14S[0]), int'(sample_R14S[1])});
        if (!haltUp_RnnnnL) lowcnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_box(input int llx, input int lly, input int urx, input int ury,
                            input logic [3:0] sub, input int tag);
        bit acc;
        int n;
        box_R13S[0][0] = fix_t'(llx);
        box_R13S[0][1] = fix_t'(lly);
        box_R13S[1][0] = fix_t'(urx);
        box_R13S[1][1] = fix_t'(ury);
        for (int i = 0; i < VERTS; i++)
            for (int j = 0; j < AXIS; j++)
                tri_R13S[i][j] = fix_t'(tag * 'h100 + i * 16 + j);
        for (int i = 0; i < COLORS; i++) color_R13U[i] = SIGFIG'(tag * 'h1000 + i);
        subSample_RnnnnU = sub;
        validTri_R13H = 1;
        n = 0;
        do begin
            @(negedge clk);
            acc = haltUp_RnnnnL;
            @(posedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", 256'(0), 256'(1));
        #2 validTri_R13H = 0;
    endtask

    task automatic check_log(input string nm, input int n);
        chk({nm, "_count"}, 256'(logq.size()), 256'(n));
        for (int i = 0; i < n && i < logq.size(); i++) begin
            chk({nm, "_x"}, 256'(logq[i].x), 256'(wx[i]));
            chk({nm, "_y"}, 256'(logq[i].y), 256'(wy[i]));
        end
    endtask

    initial begin
        rst = 1;
        halt_RnnnnL = 1;
        validTri_R13H = 0;
        subSample_RnnnnU = 4'b1000;
        tri_R13S = '0;
        color_R13U = '0;
        box_R13S = '0;
        #1 rst = 0;
        idle(3);
        chk("rst_valid", 256'(validSamp_R14H), 256'(0));
        chk("rst_sample", 256'(sample_R14S), 256'(0));
        chk("rst_haltUp", 256'(haltUp_RnnnnL), 256'(1));
        rst = 1;
        idle(1);
        halt_RnnnnL = 0;
        #1 chk("idle_haltUp_lo", 256'(haltUp_RnnnnL), 256'(0));
        idle(1);
        halt_RnnnnL = 1;
        #1 chk("idle_haltUp_hi", 256'(haltUp_RnnnnL), 256'(1));
        chk("idle_valid", 256'(validSamp_R14H), 256'(0));

        wx = '{'h800, 'hC00, 'h800, 'hC00, 0, 0, 0, 0};
        wy = '{'hC00, 'hC00, 'h1000, 'h1000, 0, 0, 0, 0};
        logq.delete();
        lowcnt = 0;
        send_box('h800, 'hC00, 'hC00, 'h1000, 4'b1000, 1);
        idle(8);
        check_log("box1x", 4);
        chk("box1x_lowcnt", 256'(lowcnt), 256'(3));

        logq.delete();
        lowcnt = 0;
        send_box('h800, 'hC00, 'hC00, 'h1000, 4'b1000, 2);
        idle(1);
        halt_RnnnnL = 0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_x", 256'(sample_R14S[0]), 256'('hC00));
            chk("stall_y", 256'(sample_R14S[1]), 256'('hC00));
            chk("stall_haltUp", 256'(haltUp_RnnnnL), 256'(0));
        end
        @(posedge clk);
        #2 halt_RnnnnL = 1;
        idle(8);
        check_log("stall", 4);
        chk("stall_lowcnt", 256'(lowcnt), 256'(6));

        wx = '{'h400, 0, 'h200, 'h400, 0, 'h200, 'h400, 0};
        wy = '{'h400, 0, 0, 0, 'h200, 'h200, 'h200, 0};
        logq.delete();
        lowcnt = 0;
        send_box('h400, 'h400, 'h400, 'h400, 4'b1000, 3);
        send_box(0, 0, 'h400, 'h200, 4'b0100, 4);
        idle(10);
        check_log("single_then_4x", 7);
        chk("single_lowcnt", 256'(lowcnt), 256'(5));

        send_box('h800, 'hC00, 'hC00, 'h1000, 4'b1000, 5);
        idle(1);
        rst = 0;
        #1 chk("midrst_valid", 256'(validSamp_R14H), 256'(0));
        chk("midrst_sample", 256'(sample_R14S), 256'(0));
        chk("midrst_haltUp", 256'(haltUp_RnnnnL), 256'(1));
        idle(1);
        rst = 1;
        wx = '{0, 'h200, 'h400, 0, 'h200, 'h400, 0, 0};
        wy = '{0, 0, 0, 'h200, 'h200, 'h200, 0, 0};
        logq.delete();
        send_box(0, 0, 'h400, 'h200, 4'b0100, 6);
        idle(10);
        check_log("after_rst", 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
